// File: rtl/age_ordered_issue_queue.sv
`timescale 1ns/1ps
// Age-ordered issue queue: holds entries until all condition bits are set, then issues the oldest ready one.
// Latency: enqueue and wakeup reach selection one cycle later; selection is combinational from registered state.
// Backpressure: enq_ready drops at full (registered count only); the selected entry is held while issue_ready is low.
// Build option AGEQ_ENQ_WAKEUP_BYPASS_EN: same-cycle wakeups are also applied to the entry being enqueued.
module age_ordered_issue_queue #(
   parameter int DEPTH      = 8,
   parameter int DATA_W     = 64,
   parameter int COND_W     = 2,
   parameter int WAKE_PORTS = 2
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           enq_valid,
   output logic                           enq_ready,
   input  logic [DATA_W-1:0]              enq_data,
   input  logic [COND_W-1:0]              enq_cond,
   input  logic [WAKE_PORTS-1:0]          wake_valid,
   input  logic [WAKE_PORTS*COND_W-1:0]   wake_mask,
   input  logic [WAKE_PORTS*COND_W-1:0]   wake_value,
   output logic                           issue_valid,
   input  logic                           issue_ready,
   output logic [DATA_W-1:0]              issue_data,
   output logic [$clog2(DEPTH)-1:0]       issue_idx,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   // Registered state
   logic [DEPTH-1:0]  valid_q;
   logic [DATA_W-1:0] data_q  [DEPTH];
   logic [COND_W-1:0] cond_q  [DEPTH];
   logic [DEPTH-1:0]  older_q [DEPTH];   // older_q[i][j]: slot i entered before slot j
   logic [CNT_W-1:0]  count_q;

   // Next-state
   logic [DEPTH-1:0]  valid_d;
   logic [DATA_W-1:0] data_d  [DEPTH];
   logic [COND_W-1:0] cond_d  [DEPTH];
   logic [DEPTH-1:0]  older_d [DEPTH];
   logic [CNT_W-1:0]  count_d;

   // Selection / allocation helpers
   logic [DEPTH-1:0]  entry_rdy;
   logic [DEPTH-1:0]  sel_oh;
   logic [DEPTH-1:0]  free_oh;
   logic [COND_W-1:0] cond_woken [DEPTH];
   logic [COND_W-1:0] enq_cond_eff;
   logic              enq_fire;
   logic              issue_fire;

   // Apply all active wakeup ports in ascending order; later ports overwrite earlier ones.
   function automatic logic [COND_W-1:0] apply_wake(
      input logic [COND_W-1:0]            c,
      input logic [WAKE_PORTS-1:0]        wv,
      input logic [WAKE_PORTS*COND_W-1:0] wm,
      input logic [WAKE_PORTS*COND_W-1:0] wval
   );
      logic [COND_W-1:0] r;
      r = c;
      for (int p = 0; p < WAKE_PORTS; p++) begin
         if (wv[p]) begin
            r = (r & ~wm[p*COND_W +: COND_W]) | (wval[p*COND_W +: COND_W] & wm[p*COND_W +: COND_W]);
         end
      end
      return r;
   endfunction

   // Full/empty decisions come only from the registered count, never from issue_ready.
   assign enq_ready  = (count_q < CNT_W'(DEPTH));
   assign enq_fire   = enq_valid && enq_ready && !flush;
   assign issue_fire = issue_valid && issue_ready && !flush;
   assign count      = count_q;

   // Entry readiness and oldest-ready pick: a ready slot wins if no other ready slot is older.
   always_comb begin
      entry_rdy = '0;
      sel_oh    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         entry_rdy[i] = valid_q[i] && (&cond_q[i]);
      end
      for (int i = 0; i < DEPTH; i++) begin
         sel_oh[i] = entry_rdy[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (j != i && entry_rdy[j] && older_q[j][i]) begin
               sel_oh[i] = 1'b0;
            end
         end
      end
   end

   // Issue outputs: OR-mux of the one-hot pick, zero when nothing is ready.
   always_comb begin
      issue_valid = |entry_rdy;
      issue_data  = '0;
      issue_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (sel_oh[i]) begin
            issue_data = issue_data | data_q[i];
            issue_idx  = issue_idx | IDX_W'(i);
         end
      end
   end

   // Lowest-index free slot; a slot freed by this cycle's issue is not visible here.
   always_comb begin
      free_oh = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!valid_q[i] && (free_oh == '0)) begin
            free_oh[i] = 1'b1;
         end
      end
   end

   // Wakeup results per slot and for the incoming entry.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         cond_woken[i] = apply_wake(cond_q[i], wake_valid, wake_mask, wake_value);
      end
`ifdef AGEQ_ENQ_WAKEUP_BYPASS_EN
      enq_cond_eff = apply_wake(enq_cond, wake_valid, wake_mask, wake_value);
`else
      enq_cond_eff = enq_cond;
`endif
   end

   // Next-state: flush clears everything; otherwise wakeup, then issue release, then enqueue.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      cond_d  = cond_q;
      older_d = older_q;
      count_d = count_q;
      if (flush) begin
         valid_d = '0;
         count_d = '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_d[i]  = '0;
            cond_d[i]  = '0;
            older_d[i] = '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
               cond_d[i] = cond_woken[i];
            end
         end
         if (issue_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (sel_oh[i]) begin
                  valid_d[i] = 1'b0;
                  data_d[i]  = '0;
                  cond_d[i]  = '0;
                  older_d[i] = '0;
                  for (int j = 0; j < DEPTH; j++) begin
                     older_d[j][i] = 1'b0;
                  end
               end
            end
         end
         if (enq_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (free_oh[i]) begin
                  // Every entry still valid after this cycle is older than the newcomer.
                  for (int j = 0; j < DEPTH; j++) begin
                     older_d[j][i] = valid_d[j];
                  end
                  older_d[i] = '0;
                  valid_d[i] = 1'b1;
                  data_d[i]  = enq_data;
                  cond_d[i]  = enq_cond_eff;
               end
            end
         end
         count_d = count_q + CNT_W'(enq_fire) - CNT_W'(issue_fire);
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i]  <= '0;
            cond_q[i]  <= '0;
            older_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i]  <= data_d[i];
            cond_q[i]  <= cond_d[i];
            older_q[i] <= older_d[i];
         end
      end
   end

endmodule

// File: tb/tb_age_ordered_issue_queue.sv
`timescale 1ns/1ps
// Testbench for age_ordered_issue_queue: directed scenarios plus randomized traffic.
// Reference model keeps entries in an age-ordered list and picks the first ready one.
// Outputs are sampled one time step after the input-driving point, away from the clock edge.
module tb_age_ordered_issue_queue;

   localparam int DEPTH      = 8;
   localparam int DATA_W     = 64;
   localparam int COND_W     = 2;
   localparam int WAKE_PORTS = 2;

   logic                         clock = 1'b0;
   logic                         reset;
   logic                         flush;
   logic                         enq_valid;
   logic                         enq_ready;
   logic [DATA_W-1:0]            enq_data;
   logic [COND_W-1:0]            enq_cond;
   logic [WAKE_PORTS-1:0]        wake_valid;
   logic [WAKE_PORTS*COND_W-1:0] wake_mask;
   logic [WAKE_PORTS*COND_W-1:0] wake_value;
   logic                         issue_valid;
   logic                         issue_ready;
   logic [DATA_W-1:0]            issue_data;
   logic [2:0]                   issue_idx;
   logic [3:0]                   count;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: per-slot contents plus slot numbers listed oldest first.
   bit          mv [DEPTH];
   logic [63:0] md [DEPTH];
   logic [1:0]  mc [DEPTH];
   int          age_q [$];

   always #5 clock = ~clock;

   age_ordered_issue_queue #(
      .DEPTH(DEPTH), .DATA_W(DATA_W), .COND_W(COND_W), .WAKE_PORTS(WAKE_PORTS)
   ) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data), .enq_cond(enq_cond),
      .wake_valid(wake_valid), .wake_mask(wake_mask), .wake_value(wake_value),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_data(issue_data),
      .issue_idx(issue_idx), .count(count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] wake(input logic [1:0] c, input logic [1:0] wv,
                                       input logic [3:0] wm, input logic [3:0] wval);
      logic [1:0] r;
      r = c;
      if (wv[0]) r = (r & ~wm[1:0]) | (wval[1:0] & wm[1:0]);
      if (wv[1]) r = (r & ~wm[3:2]) | (wval[3:2] & wm[3:2]);
      return r;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         mv[i] = 0; md[i] = '0; mc[i] = '0;
      end
      age_q.delete();
   endtask

   // One clock cycle: drive inputs, compare all outputs against the model, advance the model.
   task automatic cycle(input logic ev, input logic [63:0] ed, input logic [1:0] ec,
                        input logic [1:0] wv, input logic [3:0] wm, input logic [3:0] wval,
                        input logic ir, input logic fl);
      int sel;
      int free_slot;
      bit exp_rdy;
      logic [1:0] c;
      enq_valid = ev; enq_data = ed; enq_cond = ec;
      wake_valid = wv; wake_mask = wm; wake_value = wval;
      issue_ready = ir; flush = fl;
      #1;
      exp_rdy = (age_q.size() < DEPTH);
      sel = -1;
      foreach (age_q[k]) if (sel < 0 && mc[age_q[k]] == 2'b11) sel = age_q[k];
      check("enq_ready", enq_ready, exp_rdy);
      check("issue_valid", issue_valid, sel >= 0);
      check("issue_data", issue_data, (sel >= 0) ? md[sel] : 64'd0);
      check("issue_idx", issue_idx, (sel >= 0) ? sel : 0);
      check("count", count, age_q.size());
      if (fl) begin
         model_clear();
      end else begin
         free_slot = -1;
         for (int i = 0; i < DEPTH; i++) if (!mv[i] && free_slot < 0) free_slot = i;
         for (int i = 0; i < DEPTH; i++) if (mv[i]) mc[i] = wake(mc[i], wv, wm, wval);
         if (sel >= 0 && ir) begin
            mv[sel] = 0; md[sel] = '0; mc[sel] = '0;
            for (int k = 0; k < age_q.size(); k++) begin
               if (age_q[k] == sel) begin
                  age_q.delete(k);
                  break;
               end
            end
         end
         if (ev && exp_rdy) begin
            c = ec;
`ifdef AGEQ_ENQ_WAKEUP_BYPASS_EN
            c = wake(c, wv, wm, wval);
`endif
            mv[free_slot] = 1; md[free_slot] = ed; mc[free_slot] = c;
            age_q.push_back(free_slot);
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle_flush();
      cycle(0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      reset = 1'b1; flush = 0; enq_valid = 0; enq_data = '0; enq_cond = '0;
      wake_valid = '0; wake_mask = '0; wake_value = '0; issue_ready = 0;
      model_clear();
      #2;
      check("rst_enq_ready", enq_ready, 1);
      check("rst_issue_valid", issue_valid, 0);
      check("rst_issue_data", issue_data, 0);
      check("rst_issue_idx", issue_idx, 0);
      check("rst_count", count, 0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      // In-order issue of three ready entries
      cycle(1, 64'hA, 2'b11, 0, 0, 0, 0, 0);
      cycle(1, 64'hB, 2'b11, 0, 0, 0, 0, 0);
      cycle(1, 64'hC, 2'b11, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         check("order_idx", issue_idx, k);
         check("order_data", issue_data, 64'hA + k);
         cycle(0, 0, 0, 0, 0, 0, 1, 0);
      end
      check("order_count_empty", count, 0);

      // Younger ready entry bypasses older waiting one; older issues after its wakeup
      cycle(1, 64'hAA, 2'b01, 0, 0, 0, 0, 0);
      cycle(1, 64'hBB, 2'b11, 0, 0, 0, 0, 0);
      check("wake_first_idx", issue_idx, 1);
      cycle(0, 0, 0, 2'b01, 4'b0010, 4'b0010, 1, 0);
      check("wake_second_valid", issue_valid, 1);
      check("wake_second_data", issue_data, 64'hAA);
      cycle(0, 0, 0, 0, 0, 0, 1, 0);
      check("wake_count_empty", count, 0);

      // Fill to capacity, drop extra enqueue, free one slot
      for (int k = 0; k < DEPTH; k++) cycle(1, 64'h100 + k, 2'b00, 0, 0, 0, 0, 0);
      check("full_enq_ready", enq_ready, 0);
      check("full_count", count, 8);
      cycle(1, 64'hDEAD, 2'b11, 0, 0, 0, 0, 0);
      check("full_drop_count", count, 8);
      cycle(0, 0, 0, 2'b01, 4'b0011, 4'b0011, 0, 0);
      check("full_oldest_idx", issue_idx, 0);
      cycle(0, 0, 0, 0, 0, 0, 1, 0);
      check("full_enq_ready_after", enq_ready, 1);
      check("full_count_after", count, 7);
      idle_flush();

      // Overlapping wakeup ports: port 1 wins on bit 0
      cycle(1, 64'h39, 2'b10, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 2'b11, 4'b0101, 4'b0001, 0, 0);
      check("port_prio_not_ready", issue_valid, 0);
      cycle(0, 0, 0, 2'b01, 4'b0001, 4'b0001, 0, 0);
      check("port_prio_then_ready", issue_valid, 1);
      idle_flush();

      // Wakeup in the enqueue cycle
      cycle(1, 64'h40, 2'b00, 2'b01, 4'b0011, 4'b0011, 0, 0);
`ifdef AGEQ_ENQ_WAKEUP_BYPASS_EN
      check("enq_bypass_valid", issue_valid, 1);
`else
      check("enq_bypass_valid", issue_valid, 0);
`endif
      idle_flush();

      // Flush beats concurrent enqueue and issue
      for (int k = 0; k < 5; k++) cycle(1, 64'h200 + k, 2'b11, 0, 0, 0, 0, 0);
      cycle(1, 64'h2FF, 2'b11, 0, 0, 0, 1, 1);
      check("flush_count", count, 0);
      check("flush_issue_valid", issue_valid, 0);
      cycle(1, 64'h300, 2'b11, 0, 0, 0, 0, 0);
      check("flush_reuse_idx", issue_idx, 0);
      check("flush_reuse_valid", issue_valid, 1);
      idle_flush();

      // Randomized traffic with one reset mid-run
      for (int n = 0; n < 1500; n++) begin
         if (n == 700) begin
            cycle(1, 64'h77, 2'b11, 0, 0, 0, 0, 0);
            reset = 1'b1;
            #1;
            check("midrst_count", count, 0);
            check("midrst_issue_valid", issue_valid, 0);
            check("midrst_enq_ready", enq_ready, 1);
            check("midrst_issue_idx", issue_idx, 0);
            model_clear();
            @(posedge clock);
            #1;
            reset = 1'b0;
         end
         cycle($urandom_range(0, 99) < 60, {$urandom, $urandom}, 2'($urandom),
               {$urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25},
               4'($urandom), 4'($urandom),
               $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 2);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
